cycle_interval_timer: RTL and testbench

- Downstream consumer of the free-running 32-bit cycle counter. Measures software-delimited intervals for performance measurement on the memory-mapped bus.
- Start/Stop pulses from the bus decode timestamp the incoming count. The block computes the elapsed cycles, accumulates a total, and counts completed intervals.
- Results are exposed through a small registered read port that the memory-mapped I/O mux reads.

---
 rtl/perf_pkg.sv | 16 +
 rtl/sat_accum.sv | 20 ++
 rtl/cycle_interval_timer.sv | 166 ++++++++++++++++
 tb/tb_cycle_interval_timer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the cycle interval timer: state encoding, read map, default width.
package perf_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  localparam logic [1:0] ADDR_LAST  = 2'd0;
  localparam logic [1:0] ADDR_TOTAL = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;
  localparam logic [1:0] ADDR_AUX   = 2'd3;

endpackage

// File: rtl/sat_accum.sv
// Combinational saturating adder; sat_o flags that the true sum did not fit in Width bits.
module sat_accum #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] acc_i,
  input  logic [Width-1:0] addend_i,
  output logic [Width-1:0] sum_o,
  output logic             sat_o
);

  logic [Width:0] full_sum;

  // Carry-out of the widened add marks overflow; clamp the result to all-ones.
  always_comb begin
    full_sum = {1'b0, acc_i} + {1'b0, addend_i};
    sat_o    = full_sum[Width];
    sum_o    = sat_o ? {Width{1'b1}} : full_sum[Width-1:0];
  end

endmodule

// File: rtl/cycle_interval_timer.sv
// Interval timer fed by the free-running cycle counter. Start/Stop pulses timestamp the count;
// closed intervals update last elapsed, a saturating total and a saturating interval count.
// Results are read through a registered 1-cycle-latency port.
// Build option: define CYCLE_TIMER_MAX_EN to add a MaxElapsed register on read address 3;
// otherwise address 3 returns a status word {.., cnt_sat, total_sat, running}.
module cycle_interval_timer
  import perf_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] CycleCount,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Clear,
  input  logic [1:0]       RdAddr,
  output logic [WIDTH-1:0] RdData,
  output logic             Running,
  output logic             Done
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     stamp_q, stamp_d;
  logic [WIDTH-1:0]     last_q, last_d;
  logic [WIDTH-1:0]     total_q, total_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 total_sat_q, total_sat_d;
  logic                 cnt_sat_q, cnt_sat_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     rd_data_q, rd_data_d;
`ifdef CYCLE_TIMER_MAX_EN
  logic [WIDTH-1:0]     max_q, max_d;
`endif

  logic [WIDTH-1:0]     live_elapsed;
  logic [WIDTH-1:0]     total_sum;
  logic                 total_ovf;
  logic [CNT_WIDTH-1:0] cnt_sum;
  logic                 cnt_ovf;
  logic                 open_evt;
  logic                 close_evt;

  // Modular subtraction keeps the elapsed value correct across one counter wrap.
  assign live_elapsed = CycleCount - stamp_q;

  // Start is only honoured in IDLE and Stop only in RUNNING, which resolves simultaneous pulses.
  assign open_evt  = (state_q == ST_IDLE) && Start;
  assign close_evt = (state_q == ST_RUNNING) && Stop;

  sat_accum #(
    .Width (WIDTH)
  ) u_total_accum (
    .acc_i    (total_q),
    .addend_i (live_elapsed),
    .sum_o    (total_sum),
    .sat_o    (total_ovf)
  );

  sat_accum #(
    .Width (CNT_WIDTH)
  ) u_cnt_accum (
    .acc_i    (cnt_q),
    .addend_i (CntOne),
    .sum_o    (cnt_sum),
    .sat_o    (cnt_ovf)
  );

  // Next-state for FSM, stamp and result registers; Clear overrides every event.
  always_comb begin
    state_d     = state_q;
    stamp_d     = stamp_q;
    last_d      = last_q;
    total_d     = total_q;
    cnt_d       = cnt_q;
    total_sat_d = total_sat_q;
    cnt_sat_d   = cnt_sat_q;
    done_d      = 1'b0;
`ifdef CYCLE_TIMER_MAX_EN
    max_d       = max_q;
`endif
    if (Clear) begin
      state_d     = ST_IDLE;
      stamp_d     = '0;
      last_d      = '0;
      total_d     = '0;
      cnt_d       = '0;
      total_sat_d = 1'b0;
      cnt_sat_d   = 1'b0;
`ifdef CYCLE_TIMER_MAX_EN
      max_d       = '0;
`endif
    end else if (open_evt) begin
      state_d = ST_RUNNING;
      stamp_d = CycleCount;
    end else if (close_evt) begin
      state_d     = ST_IDLE;
      last_d      = live_elapsed;
      total_d     = total_sum;
      cnt_d       = cnt_sum;
      total_sat_d = total_sat_q | total_ovf;
      cnt_sat_d   = cnt_sat_q | cnt_ovf;
      done_d      = 1'b1;
`ifdef CYCLE_TIMER_MAX_EN
      if (live_elapsed > max_q) begin
        max_d = live_elapsed;
      end
`endif
    end
  end

  // Read mux sampled into RdData; address 0 shows the live count while an interval is open.
  always_comb begin
    rd_data_d = '0;
    unique case (RdAddr)
      ADDR_LAST:  rd_data_d = (state_q == ST_RUNNING) ? live_elapsed : last_q;
      ADDR_TOTAL: rd_data_d = total_q;
      ADDR_COUNT: rd_data_d = WIDTH'(cnt_q);
`ifdef CYCLE_TIMER_MAX_EN
      ADDR_AUX:   rd_data_d = max_q;
`else
      ADDR_AUX:   rd_data_d = WIDTH'({cnt_sat_q, total_sat_q, state_q == ST_RUNNING});
`endif
      default:    rd_data_d = '0;
    endcase
  end

  // All state, with asynchronous reset aborting any open interval.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      stamp_q     <= '0;
      last_q      <= '0;
      total_q     <= '0;
      cnt_q       <= '0;
      total_sat_q <= 1'b0;
      cnt_sat_q   <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
`ifdef CYCLE_TIMER_MAX_EN
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stamp_q     <= stamp_d;
      last_q      <= last_d;
      total_q     <= total_d;
      cnt_q       <= cnt_d;
      total_sat_q <= total_sat_d;
      cnt_sat_q   <= cnt_sat_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
`ifdef CYCLE_TIMER_MAX_EN
      max_q       <= max_d;
`endif
    end
  end

  assign Running = (state_q == ST_RUNNING);
  assign Done    = done_q;
  assign RdData  = rd_data_q;

endmodule

// File: tb/tb_cycle_interval_timer.sv
// Directed self-checking bench for cycle_interval_timer (CycleCount driven explicitly).
module tb_cycle_interval_timer;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] CycleCount = '0;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        Clear = 1'b0;
  logic [1:0]  RdAddr = 2'd0;
  logic [31:0] RdData;
  logic        Running;
  logic        Done;

  int n_pass = 0;
  int n_total = 0;

  cycle_interval_timer #(
    .WIDTH     (32),
    .CNT_WIDTH (16)
  ) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .CycleCount (CycleCount),
    .Start      (Start),
    .Stop       (Stop),
    .Clear      (Clear),
    .RdAddr     (RdAddr),
    .RdData     (RdData),
    .Running    (Running),
    .Done       (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock with the given pulses; pulses drop right after the edge.
  task automatic cyc(input logic [31:0] cc, input logic st, input logic sp, input logic clr);
    CycleCount = cc;
    Start = st;
    Stop = sp;
    Clear = clr;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    Stop = 1'b0;
    Clear = 1'b0;
  endtask

  // Registered read: present address, take one edge, compare.
  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    RdAddr = addr;
    @(posedge CLK);
    #1;
    check(tag, RdData, exp);
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(posedge CLK);
    #1;
    Reset_n = 1'b1;
    check("rst_running", {31'd0, Running}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    rd(2'd0, 32'd0, "rst_addr0");
    rd(2'd1, 32'd0, "rst_addr1");
    rd(2'd2, 32'd0, "rst_addr2");
    rd(2'd3, 32'd0, "rst_addr3");

    // Basic interval 100 -> 150
    cyc(32'd100, 1'b1, 1'b0, 1'b0);
    check("basic_running", {31'd0, Running}, 32'd1);
    cyc(32'd150, 1'b0, 1'b1, 1'b0);
    check("basic_done", {31'd0, Done}, 32'd1);
    check("basic_running_off", {31'd0, Running}, 32'd0);
    rd(2'd0, 32'd50, "basic_last");
    check("basic_done_pulse", {31'd0, Done}, 32'd0);
    rd(2'd1, 32'd50, "basic_total");
    rd(2'd2, 32'd1, "basic_count");

    // Stop while idle ignored
    cyc(32'd400, 1'b0, 1'b1, 1'b0);
    check("idle_stop_done", {31'd0, Done}, 32'd0);
    rd(2'd2, 32'd1, "idle_stop_count");

    // Wrap-around: total 50+32 = 0x52
    cyc(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
    cyc(32'h0000_0010, 1'b0, 1'b1, 1'b0);
    rd(2'd0, 32'h20, "wrap_last");
    rd(2'd1, 32'h52, "wrap_total");

    // Live read 30 cycles in, Start while running ignored; total 0x70
    cyc(32'd1000, 1'b1, 1'b0, 1'b0);
    cyc(32'd1010, 1'b1, 1'b0, 1'b0);
    CycleCount = 32'd1030;
    rd(2'd0, 32'd30, "live_read");
    cyc(32'd1030, 1'b0, 1'b1, 1'b0);
    rd(2'd0, 32'd30, "live_last");
    rd(2'd1, 32'h70, "live_total");

    // Start+Stop in IDLE opens; in RUNNING closes. total 0x7A, count 4
    cyc(32'd2000, 1'b1, 1'b1, 1'b0);
    check("both_idle_running", {31'd0, Running}, 32'd1);
    cyc(32'd2010, 1'b1, 1'b1, 1'b0);
    check("both_run_running", {31'd0, Running}, 32'd0);
    check("both_run_done", {31'd0, Done}, 32'd1);
    rd(2'd0, 32'd10, "both_last");
    rd(2'd2, 32'd4, "both_count");

    // Saturation of Total
    cyc(32'd0, 1'b1, 1'b0, 1'b0);
    cyc(32'hFFFF_FF00, 1'b0, 1'b1, 1'b0);
    rd(2'd1, 32'hFFFF_FF7A, "sat_pre_total");
    cyc(32'd0, 1'b1, 1'b0, 1'b0);
    cyc(32'h0000_0100, 1'b0, 1'b1, 1'b0);
    rd(2'd1, 32'hFFFF_FFFF, "sat_total");
    rd(2'd2, 32'd6, "sat_count");
`ifdef CYCLE_TIMER_MAX_EN
    rd(2'd3, 32'hFFFF_FF00, "sat_max");
`else
    rd(2'd3, 32'h2, "sat_status");
`endif

    // Clear together with Stop
    cyc(32'd5000, 1'b1, 1'b0, 1'b0);
    cyc(32'd5050, 1'b0, 1'b1, 1'b1);
    check("clr_running", {31'd0, Running}, 32'd0);
    check("clr_done", {31'd0, Done}, 32'd0);
    rd(2'd0, 32'd0, "clr_last");
    rd(2'd1, 32'd0, "clr_total");
    rd(2'd2, 32'd0, "clr_count");
    rd(2'd3, 32'd0, "clr_aux");

    // Intervals 40, 90, 60
    cyc(32'd100, 1'b1, 1'b0, 1'b0);
    cyc(32'd140, 1'b0, 1'b1, 1'b0);
    cyc(32'd200, 1'b1, 1'b0, 1'b0);
    cyc(32'd290, 1'b0, 1'b1, 1'b0);
    cyc(32'd300, 1'b1, 1'b0, 1'b0);
    cyc(32'd360, 1'b0, 1'b1, 1'b0);
    rd(2'd0, 32'd60, "three_last");
    rd(2'd1, 32'd190, "three_total");
    rd(2'd2, 32'd3, "three_count");
`ifdef CYCLE_TIMER_MAX_EN
    rd(2'd3, 32'd90, "three_max");
`else
    rd(2'd3, 32'd0, "three_status");
    cyc(32'd400, 1'b1, 1'b0, 1'b0);
    rd(2'd3, 32'd1, "status_running");
    cyc(32'd410, 1'b0, 1'b1, 1'b0);
`endif

    // Reset mid-interval aborts without counting
    cyc(32'd0, 1'b0, 1'b0, 1'b1);
    cyc(32'd7000, 1'b1, 1'b0, 1'b0);
    check("abort_running_before", {31'd0, Running}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("abort_running", {31'd0, Running}, 32'd0);
    CycleCount = 32'd7050;
    Stop = 1'b1;
    @(posedge CLK);
    #1;
    Stop = 1'b0;
    Reset_n = 1'b1;
    check("abort_done", {31'd0, Done}, 32'd0);
    rd(2'd2, 32'd0, "abort_count");
    rd(2'd1, 32'd0, "abort_total");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
